// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline register with an optional 2-entry skid buffer, a synchronous flush
// and a saturating stall counter. SKID=1 registers ready_o; SKID=0 passes ready_i through combinationally.
module pipe_stage_skid #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] r_main;
  logic              r_valid;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_ready;
  logic              w_acc;
  logic              w_pop;

  assign w_acc = valid_i && w_ready;
  assign w_pop = r_valid && ready_i;

  // Stall counter: saturates, survives flush, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
    end else if (r_valid && !ready_i && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_BUSY  = 2'd1,
        S_FULL  = 2'd2
      } state_t;

      state_t            r_state;
      state_t            w_state_nxt;
      logic [DATA_W-1:0] r_skid;
      logic              r_ready;
      logic              w_main_ld;
      logic              w_main_from_skid;
      logic              w_skid_ld;

      // State register; valid/ready are registered decodes of the next state.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_state <= S_EMPTY;
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_main  <= '0;
          r_skid  <= '0;
        end else begin
          r_state <= w_state_nxt;
          r_valid <= (w_state_nxt != S_EMPTY);
          r_ready <= (w_state_nxt != S_FULL);
          if (w_main_ld) begin
            r_main <= w_main_from_skid ? r_skid : data_i;
          end
          if (w_skid_ld) begin
            r_skid <= data_i;
          end
        end
      end

      always_comb begin
        w_state_nxt      = r_state;
        w_main_ld        = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_ld        = 1'b0;
        if (flush_i) begin
          w_state_nxt = S_EMPTY;
        end else begin
          case (r_state)
            S_EMPTY: begin
              if (w_acc) begin
                w_main_ld   = 1'b1;
                w_state_nxt = S_BUSY;
              end
            end
            S_BUSY: begin
              if (w_acc && w_pop) begin
                w_main_ld = 1'b1;
              end else if (w_acc) begin
                w_skid_ld   = 1'b1;
                w_state_nxt = S_FULL;
              end else if (w_pop) begin
                w_state_nxt = S_EMPTY;
              end
            end
            S_FULL: begin
              if (w_pop) begin
                w_main_ld        = 1'b1;
                w_main_from_skid = 1'b1;
                w_state_nxt      = S_BUSY;
              end
            end
            default: w_state_nxt = S_EMPTY;
          endcase
        end
      end

      assign w_ready = r_ready;
    end else begin : g_noskid
      // Single register: accept whenever empty or draining this cycle.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_valid <= 1'b0;
          r_main  <= '0;
        end else if (flush_i) begin
          r_valid <= 1'b0;
        end else if (w_acc) begin
          r_valid <= 1'b1;
          r_main  <= data_i;
        end else if (w_pop) begin
          r_valid <= 1'b0;
        end
      end

      assign w_ready = !r_valid || ready_i;
    end
  endgenerate

  assign ready_o     = w_ready;
  assign valid_o     = r_valid;
  assign data_o      = r_main;
  assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: three instances (SKID=1, SKID=0, SKID=1 with 3-bit counter)
// share stimulus and are checked every cycle against a FIFO-occupancy model.
module tb_pipe_stage_skid;

  localparam int unsigned DW = 16;
  localparam int unsigned QD = 1024;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          flush_i = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_i = 1'b0;
  logic [DW-1:0] data_i  = '0;

  logic          rdy1, v1, rdy0, v0, rdy3, v3;
  logic [DW-1:0] d1, d0, d3;
  logic [15:0]   c1, c0;
  logic [2:0]    c3;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .SKID(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .flush_i(flush_i), .valid_i(valid_i), .ready_o(rdy1),
    .data_i(data_i), .valid_o(v1), .ready_i(ready_i), .data_o(d1), .stall_cnt_o(c1));
  pipe_stage_skid #(.DATA_W(DW), .SKID(0), .CNT_W(16)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .flush_i(flush_i), .valid_i(valid_i), .ready_o(rdy0),
    .data_i(data_i), .valid_o(v0), .ready_i(ready_i), .data_o(d0), .stall_cnt_o(c0));
  pipe_stage_skid #(.DATA_W(DW), .SKID(1), .CNT_W(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .flush_i(flush_i), .valid_i(valid_i), .ready_o(rdy3),
    .data_i(data_i), .valid_o(v3), .ready_i(ready_i), .data_o(d3), .stall_cnt_o(c3));

  logic          dr[3];
  logic          dv[3];
  logic [DW-1:0] dd[3];
  logic [15:0]   dc[3];
  assign dr[0] = rdy1; assign dv[0] = v1; assign dd[0] = d1; assign dc[0] = c1;
  assign dr[1] = rdy0; assign dv[1] = v0; assign dd[1] = d0; assign dc[1] = c0;
  assign dr[2] = rdy3; assign dv[2] = v3; assign dd[2] = d3; assign dc[2] = {13'b0, c3};

  // Model: per instance, a FIFO of accepted payloads (head/tail ring) and a stall count.
  logic [DW-1:0] mbuf[3][QD];
  int            mhd[3];
  int            mtl[3];
  int            mcnt[3];
  int            cmax[3]  = '{65535, 65535, 7};
  int            mdepth[3] = '{2, 1, 2};
  bit            mskid[3] = '{1'b1, 1'b0, 1'b1};

  logic          pv[3];
  logic [DW-1:0] pd[3];
  logic          pri;
  bit            prev_ok;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic int msize(int k);
    return mtl[k] - mhd[k];
  endfunction

  function automatic logic m_ready(int k);
    if (mskid[k]) return msize(k) < mdepth[k];
    return (msize(k) == 0) || ready_i;
  endfunction

  task automatic cmp(string nm, int k, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, plus the hold-while-stalled rule.
  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      cmp("ready_o", k, 32'(dr[k]), 32'(m_ready(k)));
      cmp("valid_o", k, 32'(dv[k]), 32'(msize(k) > 0));
      if (msize(k) > 0) cmp("data_o", k, 32'(dd[k]), 32'(mbuf[k][mhd[k] % QD]));
      cmp("stall_cnt", k, 32'(dc[k]), 32'(mcnt[k]));
      if (prev_ok && pv[k] && !pri) begin
        cmp("hold_valid", k, 32'(dv[k]), 32'd1);
        cmp("hold_data", k, 32'(dd[k]), 32'(pd[k]));
      end
      pv[k] = dv[k];
      pd[k] = dd[k];
    end
    pri     = ready_i;
    prev_ok = !flush_i;
  endtask

  task automatic update_model();
    for (int k = 0; k < 3; k++) begin
      int  sz;
      bit  acc, pop;
      sz  = msize(k);
      acc = valid_i && m_ready(k);
      pop = (sz > 0) && ready_i;
      if ((sz > 0) && !ready_i && (mcnt[k] < cmax[k])) mcnt[k]++;
      if (flush_i) begin
        mhd[k] = mtl[k];
      end else begin
        if (pop) mhd[k]++;
        if (acc) begin
          mbuf[k][mtl[k] % QD] = data_i;
          mtl[k]++;
        end
      end
    end
  endtask

  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
    @(negedge clk);
    valid_i = v; data_i = d; ready_i = r; flush_i = f;
    #1 check_all();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    valid_i = 1'b0; data_i = '0; ready_i = 1'b0; flush_i = 1'b0;
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      cmp("rst_valid", k, 32'(dv[k]), 32'd0);
      cmp("rst_data", k, 32'(dd[k]), 32'd0);
      cmp("rst_ready", k, 32'(dr[k]), 32'd1);
      cmp("rst_stall", k, 32'(dc[k]), 32'd0);
      mhd[k] = 0; mtl[k] = 0; mcnt[k] = 0;
    end
    prev_ok = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      mhd[k] = 0; mtl[k] = 0; mcnt[k] = 0; pv[k] = 1'b0; pd[k] = '0;
    end
    pri = 1'b0;
    prev_ok = 1'b0;

    // Streaming with ready_i=1: one-cycle latency, no bubbles.
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, DW'(i), 1'b1, 1'b0);
      cmp("t1_valid", 0, 32'(v1), 32'd1);
      cmp("t1_data", 0, 32'(d1), 32'(i));
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    cmp("t1_drain", 0, 32'(v1), 32'd0);
    cmp("t1_stall", 0, 32'(c1), 32'd0);

    // Fill to FULL with ready_i=0, then drain.
    cycle(1'b1, 16'h000A, 1'b0, 1'b0);
    cmp("t2_ready_a", 0, 32'(rdy1), 32'd1);
    cycle(1'b1, 16'h000B, 1'b0, 1'b0);
    cmp("t2_ready_full", 0, 32'(rdy1), 32'd0);
    cmp("t2_data_a", 0, 32'(d1), 32'h000A);
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b0);
    cmp("t2_stall", 0, 32'(c1), 32'd4);
    cmp("t2_hold_a", 0, 32'(d1), 32'h000A);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cmp("t2_data_b", 0, 32'(d1), 32'h000B);
    cmp("t2_ready_back", 0, 32'(rdy1), 32'd1);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cmp("t2_empty", 0, 32'(v1), 32'd0);

    // Flush in FULL while presenting 0xC: dropped; 0xD passes alone.
    cycle(1'b1, 16'h001A, 1'b0, 1'b0);
    cycle(1'b1, 16'h001B, 1'b0, 1'b0);
    cycle(1'b1, 16'h000C, 1'b0, 1'b1);
    cmp("t4_flush_valid", 0, 32'(v1), 32'd0);
    cmp("t4_flush_ready", 0, 32'(rdy1), 32'd1);
    cycle(1'b1, 16'h000D, 1'b1, 1'b0);
    cmp("t4_valid_d", 0, 32'(v1), 32'd1);
    cmp("t4_data_d", 0, 32'(d1), 32'h000D);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cmp("t4_alone", 0, 32'(v1), 32'd0);

    // Saturating counter on the 3-bit instance.
    do_reset();
    cycle(1'b1, 16'h0055, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b0, '0, 1'b0, 1'b0);
      if (i == 7 || i == 10) cmp("t5_sat", 2, 32'(c3), 32'd7);
    end
    cmp("t5_wide", 0, 32'(c1), 32'd10);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Reset while FULL, then a single transfer.
    cycle(1'b1, 16'h0021, 1'b0, 1'b0);
    cycle(1'b1, 16'h0022, 1'b0, 1'b0);
    cmp("t6_full", 0, 32'(rdy1), 32'd0);
    do_reset();
    cycle(1'b1, 16'h0005, 1'b1, 1'b0);
    cmp("t6_valid", 0, 32'(v1), 32'd1);
    cmp("t6_data", 0, 32'(d1), 32'h0005);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Random traffic with phases of high, medium and low downstream readiness.
    for (int i = 0; i < 10000; i++) begin
      int unsigned rp;
      rp = ((i / 500) % 3 == 0) ? 90 : (((i / 500) % 3 == 1) ? 50 : 10);
      cycle(1'($urandom_range(0, 99) < 70), DW'($urandom), 1'($urandom_range(0, 99) < rp),
            1'($urandom_range(0, 199) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
